// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and FSM encoding for the UART transmit queue.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_DEFAULT_DEPTH   = 16;
    localparam int c_DEFAULT_TIMEOUT = 4096;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t c_ST_IDLE    = 2'd0;
    localparam tx_state_t c_ST_LOAD    = 2'd1;
    localparam tx_state_t c_ST_SEND    = 2'd2;
    localparam tx_state_t c_ST_RELEASE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_fifo
// Brief    : Circular byte FIFO with occupancy count and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic                   clk11,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [7:0]             i_push_data,
    input  logic                   i_pop,
    output logic [7:0]             o_pop_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_overflow
);

    // DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
    localparam int                c_AW         = $clog2(DEPTH);
    localparam logic [c_AW-1:0]   c_PTR_ONE    = (c_AW)'(1);
    localparam logic [c_AW:0]     c_CNT_ONE    = (c_AW + 1)'(1);
    localparam logic [c_AW:0]     c_FULL_COUNT = (c_AW + 1)'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full     = (r_count == c_FULL_COUNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk11) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk11) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (i_push && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Brief    : Byte queue feeding a UART writer through a re/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH   = c_DEFAULT_DEPTH,
    parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
    input  logic                   clk11,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             push_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   tx_re,
    output logic                   tx_we,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   timeout_err
);

    // TIMEOUT must be >= 2; the counter only needs to reach TIMEOUT-1.
    localparam int                c_WD_W    = $clog2(TIMEOUT);
    localparam logic [c_WD_W-1:0] c_WD_LAST = (c_WD_W)'(TIMEOUT - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = (c_WD_W)'(1);

    tx_state_t         r_state;
    logic              r_tx_re;
    logic [7:0]        r_tx_data;
    logic [c_WD_W-1:0] r_wd;
    logic              r_timeout_err;
    logic              w_pop;
    logic [7:0]        w_pop_data;

    assign w_pop       = (r_state == c_ST_LOAD);
    assign tx_re       = r_tx_re;
    assign tx_we       = 1'b0;
    assign tx_data     = r_tx_data;
    assign busy        = (r_state != c_ST_IDLE);
    assign timeout_err = r_timeout_err;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk11       (clk11),
        .rst         (rst),
        .i_push      (push),
        .i_push_data (push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_count     (level),
        .o_full      (full),
        .o_empty     (empty),
        .o_overflow  (overflow)
    );

    always_ff @(posedge clk11) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_tx_re       <= 1'b0;
            r_tx_data     <= 8'h00;
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!empty) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_tx_data <= w_pop_data;
                    r_wd      <= '0;
                    r_tx_re   <= 1'b1;
                    r_state   <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    // A timed-out byte is already popped and is simply dropped.
                    if (tx_done) begin
                        r_tx_re <= 1'b0;
                        r_state <= c_ST_RELEASE;
                    end else if (r_wd == c_WD_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_tx_re       <= 1'b0;
                        r_state       <= c_ST_RELEASE;
                    end else begin
                        r_wd <= r_wd + c_WD_ONE;
                    end
                end
                c_ST_RELEASE: begin
                    if (!tx_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_queue
// Brief    : Directed self-checking bench for uart_tx_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int c_DEPTH   = 16;
    localparam int c_TIMEOUT = 32;

    logic       clk11 = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] push_data;
    logic       tx_done;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       tx_re;
    logic       tx_we;
    logic [7:0] tx_data;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_fails  = 0;

    uart_tx_queue #(
        .DEPTH   (c_DEPTH),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk11       (clk11),
        .rst         (rst),
        .push        (push),
        .push_data   (push_data),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .tx_re       (tx_re),
        .tx_we       (tx_we),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk11 = ~clk11;

    task automatic tick();
        @(posedge clk11);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; push = 1'b0; push_data = 8'h00; tx_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_tx_re(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_re === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (tx_re !== 1'b0) begin n_fails++; $display("FAIL reset_tx_re: got %b want 0", tx_re); end
        n_checks++; if (tx_we !== 1'b0) begin n_fails++; $display("FAIL reset_tx_we: got %b want 0", tx_we); end
        n_checks++; if (tx_data !== 8'h00) begin n_fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fails++; $display("FAIL reset_flags: empty %b full %b want 1 0", empty, full); end
        n_checks++; if (level !== 5'd0) begin n_fails++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (overflow !== 1'b0 || timeout_err !== 1'b0) begin n_fails++; $display("FAIL reset_sticky: ovf %b tmo %b want 0 0", overflow, timeout_err); end
    endtask

    task automatic test_single();
        bit ok;
        push = 1'b1; push_data = 8'h41;
        tick();
        push = 1'b0;
        n_checks++; if (level !== 5'd1) begin n_fails++; $display("FAIL single_level: got %0d want 1", level); end
        tick();
        n_checks++; if (tx_re !== 1'b0) begin n_fails++; $display("FAIL single_early_re: got %b want 0", tx_re); end
        tick();
        n_checks++; if (tx_re !== 1'b1) begin n_fails++; $display("FAIL single_latency: tx_re %b want 1", tx_re); end
        n_checks++; if (tx_data !== 8'h41) begin n_fails++; $display("FAIL single_data: got %h want 41", tx_data); end
        n_checks++; if (level !== 5'd0) begin n_fails++; $display("FAIL single_popped: level %0d want 0", level); end
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (tx_re !== 1'b1 || tx_data !== 8'h41) ok = 1'b0;
            tick();
        end
        n_checks++; if (!ok) begin n_fails++; $display("FAIL single_hold: tx_re/tx_data changed before done, now %b/%h want 1/41", tx_re, tx_data); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_checks++; if (tx_re !== 1'b0) begin n_fails++; $display("FAIL single_release: tx_re %b want 0", tx_re); end
        tick();
        n_checks++; if (busy !== 1'b0 || empty !== 1'b1) begin n_fails++; $display("FAIL single_idle: busy %b empty %b want 0 1", busy, empty); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gap;
        push = 1'b1; push_data = 8'h11; tick();
        push_data = 8'h22; tick();
        push = 1'b0;
        wait_tx_re(10, ok);
        n_checks++; if (!ok || tx_data !== 8'h11) begin n_fails++; $display("FAIL b2b_first: re %b data %h want 1 11", tx_re, tx_data); end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        gap = 0;
        while (tx_re !== 1'b1 && gap < 20) begin gap++; tick(); end
        n_checks++; if (gap != 3) begin n_fails++; $display("FAIL b2b_gap: got %0d cycles want 3", gap); end
        n_checks++; if (tx_data !== 8'h22) begin n_fails++; $display("FAIL b2b_second: got %h want 22", tx_data); end
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
        n_checks++; if (busy !== 1'b0 || empty !== 1'b1) begin n_fails++; $display("FAIL b2b_idle: busy %b empty %b want 0 1", busy, empty); end
    endtask

    task automatic test_full_overflow();
        bit ok;
        logic [7:0] exp;
        push = 1'b1; push_data = 8'hA5; tick(); push = 1'b0;
        wait_tx_re(10, ok);
        n_checks++; if (!ok || tx_data !== 8'hA5) begin n_fails++; $display("FAIL full_prefix: re %b data %h want 1 a5", tx_re, tx_data); end
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; push_data = 8'(i); tick();
        end
        n_checks++; if (full !== 1'b1 || level !== 5'd16) begin n_fails++; $display("FAIL full_level: full %b level %0d want 1 16", full, level); end
        n_checks++; if (overflow !== 1'b0) begin n_fails++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
        push_data = 8'hFF; tick(); push = 1'b0;
        n_checks++; if (overflow !== 1'b1 || level !== 5'd16) begin n_fails++; $display("FAIL full_ovf: ovf %b level %0d want 1 16", overflow, level); end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = 8'(i);
            wait_tx_re(10, ok);
            n_checks++; if (!ok || tx_data !== exp) begin n_fails++; $display("FAIL full_order: re %b data %h want 1 %h", tx_re, tx_data, exp); end
            tx_done = 1'b1; tick(); tx_done = 1'b0;
        end
        wait_idle(10);
        n_checks++; if (busy !== 1'b0 || empty !== 1'b1 || overflow !== 1'b1) begin n_fails++; $display("FAIL full_end: busy %b empty %b ovf %b want 0 1 1", busy, empty, overflow); end
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        push = 1'b1; push_data = 8'h55; tick(); push = 1'b0;
        wait_tx_re(10, ok);
        n_checks++; if (!ok || tx_data !== 8'h55) begin n_fails++; $display("FAIL tmo_start: re %b data %h want 1 55", tx_re, tx_data); end
        hi = 0;
        while (tx_re === 1'b1 && hi < 100) begin hi++; tick(); end
        n_checks++; if (hi != c_TIMEOUT) begin n_fails++; $display("FAIL tmo_len: tx_re high %0d cycles want %0d", hi, c_TIMEOUT); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fails++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
        tick();
        n_checks++; if (busy !== 1'b0 || empty !== 1'b1) begin n_fails++; $display("FAIL tmo_idle: busy %b empty %b want 0 1", busy, empty); end
        push = 1'b1; push_data = 8'h66; tick(); push = 1'b0;
        wait_tx_re(10, ok);
        n_checks++; if (!ok || tx_data !== 8'h66) begin n_fails++; $display("FAIL tmo_next: re %b data %h want 1 66", tx_re, tx_data); end
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
        n_checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_fails++; $display("FAIL tmo_sticky: tmo %b busy %b want 1 0", timeout_err, busy); end
    endtask

    task automatic test_reset_mid_send();
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = 8'(8'h90 + i); tick();
        end
        push = 1'b0;
        n_checks++; if (tx_re !== 1'b1 || level !== 5'd3) begin n_fails++; $display("FAIL rstmid_pre: re %b level %0d want 1 3", tx_re, level); end
        n_checks++; if (overflow !== 1'b1 || timeout_err !== 1'b1) begin n_fails++; $display("FAIL rstmid_flags_pre: ovf %b tmo %b want 1 1", overflow, timeout_err); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if (tx_re !== 1'b0 || tx_data !== 8'h00) begin n_fails++; $display("FAIL rstmid_re: re %b data %h want 0 00", tx_re, tx_data); end
        n_checks++; if (level !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin n_fails++; $display("FAIL rstmid_q: level %0d empty %b busy %b want 0 1 0", level, empty, busy); end
        n_checks++; if (overflow !== 1'b0 || timeout_err !== 1'b0) begin n_fails++; $display("FAIL rstmid_flags: ovf %b tmo %b want 0 0", overflow, timeout_err); end
        tick(); tick(); tick();
        n_checks++; if (tx_re !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL rstmid_quiet: re %b busy %b want 0 0", tx_re, busy); end
    endtask

    task automatic test_done_held();
        bit ok;
        apply_reset();
        push = 1'b1; push_data = 8'h77; tick();
        push_data = 8'h78; tick(); push = 1'b0;
        wait_tx_re(10, ok);
        n_checks++; if (!ok || tx_data !== 8'h77) begin n_fails++; $display("FAIL held_first: re %b data %h want 1 77", tx_re, tx_data); end
        tx_done = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (tx_re !== 1'b0 || level !== 5'd1 || busy !== 1'b1) begin n_fails++; $display("FAIL held_stay: re %b level %0d busy %b want 0 1 1", tx_re, level, busy); end
            tick();
        end
        tx_done = 1'b0; tick();
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL held_exit: busy %b want 0", busy); end
        tick(); tick();
        n_checks++; if (tx_re !== 1'b1 || tx_data !== 8'h78) begin n_fails++; $display("FAIL held_second: re %b data %h want 1 78", tx_re, tx_data); end
        tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
    endtask

    task automatic test_load_push();
        bit ok;
        logic [7:0] exp;
        // Park the FSM in RELEASE so the queue can fill without popping.
        apply_reset();
        push = 1'b1; push_data = 8'h01; tick(); push = 1'b0;
        wait_tx_re(10, ok);
        tx_done = 1'b1; tick();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; push_data = 8'(8'h30 + i); tick();
        end
        push = 1'b0;
        n_checks++; if (level !== 5'd16 || full !== 1'b1) begin n_fails++; $display("FAIL lp16_fill: level %0d full %b want 16 1", level, full); end
        tx_done = 1'b0; tick(); tick();
        n_checks++; if (level !== 5'd16 || tx_re !== 1'b0) begin n_fails++; $display("FAIL lp16_load: level %0d re %b want 16 0", level, tx_re); end
        push = 1'b1; push_data = 8'hEE; tick(); push = 1'b0;
        n_checks++; if (level !== 5'd15 || overflow !== 1'b1) begin n_fails++; $display("FAIL lp16_reject: level %0d ovf %b want 15 1", level, overflow); end
        n_checks++; if (tx_re !== 1'b1 || tx_data !== 8'h30) begin n_fails++; $display("FAIL lp16_data: re %b data %h want 1 30", tx_re, tx_data); end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        for (int i = 1; i < 16; i++) begin
            exp = 8'(8'h30 + i);
            wait_tx_re(10, ok);
            n_checks++; if (!ok || tx_data !== exp) begin n_fails++; $display("FAIL lp16_drain: re %b data %h want 1 %h", tx_re, tx_data, exp); end
            tx_done = 1'b1; tick(); tx_done = 1'b0;
        end
        wait_idle(10);
        n_checks++; if (empty !== 1'b1 || busy !== 1'b0) begin n_fails++; $display("FAIL lp16_end: empty %b busy %b want 1 0", empty, busy); end

        apply_reset();
        push = 1'b1; push_data = 8'h01; tick(); push = 1'b0;
        wait_tx_re(10, ok);
        tx_done = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 8'(8'h50 + i); tick();
        end
        push = 1'b0;
        tx_done = 1'b0; tick(); tick();
        n_checks++; if (level !== 5'd5) begin n_fails++; $display("FAIL lp5_pre: level %0d want 5", level); end
        push = 1'b1; push_data = 8'h55; tick(); push = 1'b0;
        n_checks++; if (level !== 5'd5 || overflow !== 1'b0) begin n_fails++; $display("FAIL lp5_level: level %0d ovf %b want 5 0", level, overflow); end
        n_checks++; if (tx_re !== 1'b1 || tx_data !== 8'h50) begin n_fails++; $display("FAIL lp5_data: re %b data %h want 1 50", tx_re, tx_data); end
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        for (int i = 1; i < 6; i++) begin
            exp = 8'(8'h50 + i);
            wait_tx_re(10, ok);
            n_checks++; if (!ok || tx_data !== exp) begin n_fails++; $display("FAIL lp5_drain: re %b data %h want 1 %h", tx_re, tx_data, exp); end
            tx_done = 1'b1; tick(); tx_done = 1'b0;
        end
        wait_idle(10);
        n_checks++; if (empty !== 1'b1 || busy !== 1'b0) begin n_fails++; $display("FAIL lp5_end: empty %b busy %b want 1 0", empty, busy); end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; push_data = 8'h00; tx_done = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_overflow();
        test_timeout();
        test_reset_mid_send();
        test_done_held();
        test_load_push();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 500000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set FIFO entries; power of two only.
REQ-002 Parameter TIMEOUT, default 4096, SHALL set max clk11 cycles spent waiting for tx_done.
REQ-003 clk11  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 push  in  1  producer write strobe, one byte per cycle high.
REQ-006 push_data  in  8  byte to enqueue.
REQ-007 full  out  1  high when count == DEPTH.
REQ-008 empty  out  1  high when count == 0.
REQ-009 level  out  clog2(DEPTH)+1  current count, 0..DEPTH.
REQ-010 overflow  out  1  sticky; push rejected while full.
REQ-011 tx_re  out  1  level request to downstream UART writer ("send byte").
REQ-012 tx_we  out  1  writer receive-path request; SHALL be held 0.
REQ-013 tx_data  out  8  byte presented to the writer's data_in.
REQ-014 tx_done  in  1  writer completion flag.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  1  sticky; tx_done did not arrive within TIMEOUT.

Function
REQ-017 FIFO SHALL be circular; rd_ptr and wr_ptr wrap from DEPTH-1 to 0.
REQ-018 Push accepted iff push=1 and full=0 (registered value); data written at wr_ptr, wr_ptr+1.
REQ-019 Push with full=1 SHALL be dropped, leaving memory, pointers and count unchanged, and SHALL set overflow.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged and both pointers advanced.
REQ-021 FSM states: IDLE, LOAD, SEND, RELEASE.
REQ-022 IDLE: if empty=0 -> LOAD; else stay.
REQ-023 LOAD: tx_data <= mem[rd_ptr], rd_ptr+1, count-1 (pop); -> SEND.
REQ-024 SEND: tx_re=1, tx_data held stable; tx_done=1 -> RELEASE; watchdog reaching TIMEOUT-1 -> set timeout_err, -> RELEASE.
REQ-025 RELEASE: tx_re=0; stay until tx_done=0 observed, minimum one cycle; then -> IDLE.
REQ-026 tx_re SHALL be registered and high only in SEND; rises one cycle after LOAD.
REQ-027 Watchdog SHALL clear on SEND entry and increment every SEND cycle.
REQ-028 Latency: push into empty queue at edge N -> tx_re high at edge N+3 (IDLE, LOAD, SEND).
REQ-029 Back-to-back bytes: minimum gap between tx_re high periods is 3 cycles (RELEASE, IDLE, LOAD).
REQ-030 Byte popped before its SEND times out SHALL be discarded, not re-queued.
REQ-031 level, full, empty SHALL derive from the registered count only.

Reset
REQ-032 rst=1 at an edge SHALL set: state IDLE, pointers 0, count 0, tx_re 0, tx_we 0, tx_data 0x00, busy 0, overflow 0, timeout_err 0, watchdog 0.
REQ-033 Reset mid-SEND SHALL drop tx_re at that same edge; in-flight and queued bytes are lost.
REQ-034 FIFO memory contents need not be reset.

Structure
REQ-035 Shared package uart_pkg SHALL hold the tx state enum, default DEPTH and TIMEOUT constants.
REQ-036 Storage and pointer/count logic SHALL be sub-module uart_byte_fifo (push/pop/data/count); uart_tx_queue holds FSM and watchdog.

Verification
REQ-037 Push 0x41 into empty queue, writer model asserts tx_done 5 cycles after tx_re -> tx_re high 3 cycles after push, tx_data=0x41, then empty=1, busy=0.
REQ-038 Push 0x00..0x0F on 16 consecutive cycles with writer stalled -> full=1 and level=16 reached only if LOAD has not popped; 17th push 0xFF -> overflow=1, sent sequence exactly 0x00..0x0F in order.
REQ-039 Push during LOAD pop cycle with level=16 -> push rejected, overflow=1; with level=5 -> level stays 5.
REQ-040 tx_done tied 0, push 0x55 -> timeout_err=1 after TIMEOUT cycles in SEND, tx_re falls, FSM returns IDLE; next byte still sent.
REQ-041 tx_done held 1 for 10 cycles after handshake -> FSM stays in RELEASE until it drops, no second tx_re meanwhile.
REQ-042 rst asserted while tx_re=1 with level=3 -> next cycle tx_re=0, level=0, empty=1, busy=0, flags cleared.
